// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: parses [HDR][LEN][PAYLOAD][CHK] byte streams,
// buffers the payload and holds each good frame until the consumer accepts it.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HDR_BYTE    = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  output logic       RX_En_Sig,
  output logic       Frm_Valid,
  input  logic       Frm_Ready,
  output logic [4:0] Frm_Len,
  input  logic [3:0] Frm_Rd_Addr,
  output logic [7:0] Frm_Rd_Data,
  output logic       Err_Chk,
  output logic       Err_Len,
  output logic       Err_Tmo,
  output logic       Err_Ovf
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [4:0]         len_reg, len_next;
  logic [7:0]         sum_reg, sum_next;
  logic [3:0]         idx_reg, idx_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               en_reg, en_next;
  logic               err_chk_reg, err_chk_next;
  logic               err_len_reg, err_len_next;
  logic               err_tmo_reg, err_tmo_next;
  logic               err_ovf_reg, err_ovf_next;
  logic               buf_we;
  logic               in_frame;
  logic [7:0]         buf_reg [MAX_LEN];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= IDLE;
      len_reg     <= '0;
      sum_reg     <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      en_reg      <= 1'b0;
      err_chk_reg <= 1'b0;
      err_len_reg <= 1'b0;
      err_tmo_reg <= 1'b0;
      err_ovf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      len_reg     <= len_next;
      sum_reg     <= sum_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      en_reg      <= en_next;
      err_chk_reg <= err_chk_next;
      err_len_reg <= err_len_next;
      err_tmo_reg <= err_tmo_next;
      err_ovf_reg <= err_ovf_next;
    end
  end

  // One register per payload slot so the whole buffer clears on reset.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_buf
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
          buf_reg[gi] <= 8'h00;
        else if (buf_we && (idx_reg == 4'(gi)))
          buf_reg[gi] <= RX_Data;
      end
    end
  endgenerate

  assign in_frame = (state_reg == LEN) || (state_reg == PAYLOAD) || (state_reg == CHK);

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    sum_next     = sum_reg;
    idx_next     = idx_reg;
    cnt_next     = '0;
    err_chk_next = 1'b0;
    err_len_next = 1'b0;
    err_tmo_next = 1'b0;
    err_ovf_next = 1'b0;
    buf_we       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_Done_Sig && (RX_Data == HDR_BYTE))
          state_next = LEN;
      end
      LEN: begin
        if (RX_Done_Sig) begin
          if ((RX_Data != 8'h00) && (RX_Data <= 8'(MAX_LEN))) begin
            len_next   = RX_Data[4:0];
            sum_next   = RX_Data;
            idx_next   = '0;
            state_next = PAYLOAD;
          end else begin
            err_len_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      PAYLOAD: begin
        if (RX_Done_Sig) begin
          buf_we   = 1'b1;
          sum_next = sum_reg + RX_Data;
          if ({1'b0, idx_reg} == (len_reg - 5'd1))
            state_next = CHK;
          else
            idx_next = idx_reg + 4'd1;
        end
      end
      CHK: begin
        if (RX_Done_Sig) begin
          if (RX_Data == sum_reg) begin
            state_next = HOLD;
          end else begin
            err_chk_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      HOLD: begin
        // A byte arriving while held is lost even if the frame is accepted now.
        if (RX_Done_Sig)
          err_ovf_next = 1'b1;
        if (Frm_Ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A byte landing in the expiry cycle keeps the frame alive.
    if (in_frame && !RX_Done_Sig) begin
      if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
        err_tmo_next = 1'b1;
        state_next   = IDLE;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    en_next = (state_next != HOLD);
  end

  assign RX_En_Sig   = en_reg;
  assign Frm_Valid   = (state_reg == HOLD);
  assign Frm_Len     = len_reg;
  assign Frm_Rd_Data = ({1'b0, Frm_Rd_Addr} < len_reg) ? buf_reg[Frm_Rd_Addr] : 8'h00;
  assign Err_Chk     = err_chk_reg;
  assign Err_Len     = err_len_reg;
  assign Err_Tmo     = err_tmo_reg;
  assign Err_Ovf     = err_ovf_reg;

endmodule
